// File: rtl/irq_vector_ctrl.sv
// irq_vector_ctrl: multi-channel interrupt controller with fixed priority.
// Each source passes through a 2-flop synchroniser and is latched into a pending
// register. Channel 0 has the highest priority. The FSM (IDLE/REQ/SERVICE) raises IRQ
// and presents XVecAddr = XAddr + id*VecStride for the selected channel.
// Optional build macro: IRQ_LEVEL_EN selects level-triggered sources, where pending
// follows the synchronised input. When it is undefined, sources are edge-latched.
//
// Handshake: IRQ stays high from REQ entry until the processor pulses irq_ack for one
// cycle, or until the selected channel is masked off. irq_id and XVecAddr stay frozen
// for that whole time. irq_eoi is a one-cycle pulse that closes SERVICE. An ack is
// honoured only in REQ, and an eoi only in SERVICE.
module irq_vector_ctrl #(
  parameter int          NumIrq    = 8,
  parameter logic [31:0] XAddr     = 32'h80000008,
  parameter int          VecStride = 4,
  parameter int          IdW       = (NumIrq > 1) ? $clog2(NumIrq) : 1
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [NumIrq-1:0] irq_in,
  input  logic              mask_we,
  input  logic [NumIrq-1:0] mask_wd,
  input  logic              pc_31,
  input  logic              irq_ack,
  input  logic              irq_eoi,
  output logic              IRQ,
  output logic [31:0]       XVecAddr,
  output logic [IdW-1:0]    irq_id,
  output logic [NumIrq-1:0] pending,
  output logic              in_service,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [NumIrq-1:0] s1_q, s2_q;
  logic [NumIrq-1:0] mask_q, mask_d;
  logic [NumIrq-1:0] pend_vis;
  logic [NumIrq-1:0] req_vec;
  logic [IdW-1:0]    sel_id;
  logic [31:0]       sel_vec;
  logic              ack_take;

  logic [1:0]        state_q, state_d;
  logic              irq_q, irq_d;
  logic [IdW-1:0]    id_q, id_d;
  logic [31:0]       vec_q, vec_d;
  logic              insvc_q, insvc_d;

  // Two-flop synchroniser for the raw asynchronous sources.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= irq_in;
      s2_q <= s1_q;
    end
  end

`ifdef IRQ_LEVEL_EN
  // Level mode: pending is the synchronised level itself, and ack does not clear it.
  assign pend_vis = s2_q;
`else
  logic [NumIrq-1:0] s2d_q;
  logic [NumIrq-1:0] pending_q, pending_d;
  logic [NumIrq-1:0] edge_vec;
  logic [NumIrq-1:0] clr_vec;

  assign edge_vec = s2_q & ~s2d_q;

  // Clear the accepted channel, but a new edge in the same cycle keeps it set.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NumIrq; i++) begin
      clr_vec[i] = ack_take && (id_q == IdW'(i));
    end
    pending_d = (pending_q & ~clr_vec) | edge_vec;
  end

  // Edge detector delay flop and the pending latch.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      s2d_q     <= '0;
      pending_q <= '0;
    end else begin
      s2d_q     <= s2_q;
      pending_q <= pending_d;
    end
  end

  assign pend_vis = pending_q;
`endif

  assign req_vec = pend_vis & mask_q;

  // Fixed-priority select: the lowest set index wins. Scan from the top so the last hit is the lowest index.
  always_comb begin
    sel_id = '0;
    for (int i = NumIrq - 1; i >= 0; i--) begin
      if (req_vec[i]) sel_id = IdW'(i);
    end
    sel_vec = XAddr + (32'(sel_id) * 32'(VecStride));
  end

  // A mask write takes effect at the next edge and leaves pending untouched.
  always_comb begin
    mask_d = mask_we ? mask_wd : mask_q;
  end

  // Request FSM next-state logic. An ack takes priority over a mask withdraw.
  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    id_d     = id_q;
    vec_d    = vec_q;
    insvc_d  = insvc_q;
    ack_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|req_vec) && !pc_31) begin
          state_d = ST_REQ;
          irq_d   = 1'b1;
          id_d    = sel_id;
          vec_d   = sel_vec;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d  = ST_SERVICE;
          irq_d    = 1'b0;
          insvc_d  = 1'b1;
          ack_take = 1'b1;
        end else if (!mask_q[id_q]) begin
          state_d = ST_IDLE;
          irq_d   = 1'b0;
        end
      end
      ST_SERVICE: begin
        if (irq_eoi) begin
          state_d = ST_IDLE;
          insvc_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
        insvc_d = 1'b0;
      end
    endcase
  end

  // FSM, vector and mask registers. Reset enables every channel.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
      id_q    <= '0;
      vec_q   <= XAddr;
      insvc_q <= 1'b0;
      mask_q  <= '1;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
      insvc_q <= insvc_d;
      mask_q  <= mask_d;
    end
  end

  assign IRQ        = irq_q;
  assign XVecAddr   = vec_q;
  assign irq_id     = id_q;
  assign pending    = pend_vis;
  assign in_service = insvc_q;
  assign state_dbg  = state_q;

endmodule
